// File: rtl/event_encoder_pkg.sv
// Shared types, widths and the priority search used by the event encoder.
package event_encoder_pkg;

    localparam int N_REQ  = 16;
    localparam int CODE_W = 4;

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    // Returns the first set index found searching upward from 'start',
    // wrapping from N_REQ-1 back to 0. Returns 0 when nothing is set.
    function automatic logic [CODE_W-1:0] pick_index(
        input logic [0:N_REQ-1]  pend,
        input logic [CODE_W-1:0] start
    );
        logic [CODE_W-1:0] idx;
        logic              found;
        pick_index = '0;
        found      = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = start + CODE_W'(i);
            if (!found && pend[idx]) begin
                pick_index = idx;
                found      = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/event_encoder_sync.sv
// Multi-stage synchronizer plus rising-edge detector for a bus of
// independent asynchronous request lines.
module req_sync_edge #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [0:WIDTH-1] i_async,
    output logic [0:WIDTH-1] o_rise
);

    logic [0:WIDTH-1] r_sync [STAGES];
    logic [0:WIDTH-1] r_last;

    // Shift each line through the synchronizer and remember the previous settled value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                r_sync[s] <= '0;
            end
            r_last <= '0;
        end else begin
            r_sync[0] <= i_async;
            for (int s = 1; s < STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_last <= r_sync[STAGES-1];
        end
    end

    assign o_rise = r_sync[STAGES-1] & ~r_last;

endmodule

// File: rtl/event_encoder.sv
// Sequential 16-to-4 event encoder: latches rising edges on the request
// lines as pending events and hands them out one index at a time.
module event_encoder
    import event_encoder_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ROUND_ROBIN = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             EN,
    input  logic [0:N_REQ-1] req,
    input  logic             ready,
    output logic             o0,
    output logic             o1,
    output logic             o2,
    output logic             o3,
    output logic             valid,
    output logic             lost
);

    state_t            r_state;
    state_t            w_stateNext;
    logic [0:N_REQ-1]  r_pend;
    logic [0:N_REQ-1]  w_pendNext;
    logic [0:N_REQ-1]  w_rise;
    logic [0:N_REQ-1]  w_clr;
    logic [CODE_W-1:0] r_code;
    logic [CODE_W-1:0] w_codeNext;
    logic [CODE_W-1:0] r_ptr;
    logic [CODE_W-1:0] w_ptrNext;
    logic [CODE_W-1:0] w_pick;
    logic [CODE_W-1:0] w_start;
    logic              r_valid;
    logic              w_validNext;
    logic              r_lost;
    logic              w_lostNext;
    logic              w_accept;

    req_sync_edge #(
        .WIDTH  (N_REQ),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (req),
        .o_rise  (w_rise)
    );

    assign w_accept = r_valid && ready;
    assign w_start  = (ROUND_ROBIN != 0) ? r_ptr : CODE_W'(0);
    assign w_pick   = pick_index(r_pend, w_start);

    // Pending-event bookkeeping: new edges set, accepts clear, set beats clear,
    // and an edge on a bit that stays pending is reported as lost.
    always_comb begin
        w_clr = '0;
        if (w_accept) begin
            w_clr[r_code] = 1'b1;
        end
        w_pendNext = EN ? ((r_pend & ~w_clr) | w_rise) : '0;
        w_lostNext = EN && (|(w_rise & r_pend & ~w_clr));
    end

    // Next-state and next-output logic for the present/accept handshake.
    always_comb begin
        w_stateNext = r_state;
        w_codeNext  = r_code;
        w_validNext = r_valid;
        w_ptrNext   = r_ptr;
        if (!EN) begin
            w_stateNext = IDLE;
            w_codeNext  = '0;
            w_validNext = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|r_pend) begin
                        w_codeNext  = w_pick;
                        w_validNext = 1'b1;
                        w_stateNext = PRESENT;
                    end
                end
                PRESENT: begin
                    if (ready) begin
                        w_validNext = 1'b0;
                        w_stateNext = IDLE;
                        w_ptrNext   = r_code + CODE_W'(1);
                    end
                end
                default: begin
                    w_stateNext = IDLE;
                    w_validNext = 1'b0;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Datapath registers so every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend  <= '0;
            r_code  <= '0;
            r_valid <= 1'b0;
            r_lost  <= 1'b0;
            r_ptr   <= '0;
        end else begin
            r_pend  <= w_pendNext;
            r_code  <= w_codeNext;
            r_valid <= w_validNext;
            r_lost  <= w_lostNext;
            r_ptr   <= w_ptrNext;
        end
    end

    assign o0    = r_code[3];
    assign o1    = r_code[2];
    assign o2    = r_code[1];
    assign o3    = r_code[0];
    assign valid = r_valid;
    assign lost  = r_lost;

endmodule

// File: tb/tb_event_encoder.sv
// Scoreboard bench for event_encoder: a fixed-priority and a round-robin
// instance share the same stimulus; expected codes are queued per instance
// and checked by a monitor whenever a code is accepted.
module tb_event_encoder;
    import event_encoder_pkg::*;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             EN    = 1'b0;
    logic             ready = 1'b0;
    logic [0:N_REQ-1] req   = '0;

    logic f0, f1, f2, f3, validF, lostF;
    logic r0, r1, r2, r3, validR, lostR;
    logic [3:0] codeF, codeR;
    logic [3:0] expF, expR;

    int vecCount   = 0;
    int missCount  = 0;
    int cycle      = 0;
    int lostFixed  = 0;
    int lostRotate = 0;
    logic [3:0] expFixed[$];
    logic [3:0] expRotate[$];
    int acceptFixed[$];

    event_encoder #(.SYNC_STAGES(2), .ROUND_ROBIN(0)) dutFixed (
        .clk(clk), .rst_n(rst_n), .EN(EN), .req(req), .ready(ready),
        .o0(f0), .o1(f1), .o2(f2), .o3(f3), .valid(validF), .lost(lostF)
    );

    event_encoder #(.SYNC_STAGES(2), .ROUND_ROBIN(1)) dutRotate (
        .clk(clk), .rst_n(rst_n), .EN(EN), .req(req), .ready(ready),
        .o0(r0), .o1(r1), .o2(r2), .o3(r3), .valid(validR), .lost(lostR)
    );

    assign codeF = {f0, f1, f2, f3};
    assign codeR = {r0, r1, r2, r3};

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Monitor: pops the expected code whenever an instance hands one over.
    always @(negedge clk) begin
        if (lostF) lostFixed++;
        if (lostR) lostRotate++;
        if (validF && ready) begin
            vecCount++;
            acceptFixed.push_back(cycle);
            if (expFixed.size() == 0) begin
                missCount++;
                $display("[TB] FAIL fixed unexpected: got code %0d, required none", codeF);
            end else begin
                expF = expFixed.pop_front();
                if (codeF !== expF) begin
                    missCount++;
                    $display("[TB] FAIL fixed code: got %0d, required %0d", codeF, expF);
                end
            end
        end
        if (validR && ready) begin
            vecCount++;
            if (expRotate.size() == 0) begin
                missCount++;
                $display("[TB] FAIL rotate unexpected: got code %0d, required none", codeR);
            end else begin
                expR = expRotate.pop_front();
                if (codeR !== expR) begin
                    missCount++;
                    $display("[TB] FAIL rotate code: got %0d, required %0d", codeR, expR);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [0:N_REQ-1] mask, input int hold);
        @(posedge clk); #1;
        req = req | mask;
        repeat (hold) @(posedge clk);
        #1;
        req = req & ~mask;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitValid(input string name);
        int t = 0;
        while (!(validF && validR) && t < 15) begin
            @(posedge clk); #1;
            t++;
        end
        vecCount++;
        if (!(validF && validR)) begin
            missCount++;
            $display("[TB] FAIL %s: got valid %0b/%0b, required 1/1", name, validF, validR);
        end
    endtask

    function automatic logic [0:N_REQ-1] bitOf(input int k);
        logic [0:N_REQ-1] m;
        m    = '0;
        m[k] = 1'b1;
        return m;
    endfunction

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset fixed", int'({lostF, validF, codeF}), 0);
        checkOutput("reset rotate", int'({lostR, validR, codeR}), 0);
        rst_n = 1'b1;
        EN    = 1'b1;
        ready = 1'b1;

        // Single edge on req[9]: valid appears three edges after first sample.
        while (cycle < 10) @(posedge clk);
        #1;
        expFixed.push_back(4'd9);
        expRotate.push_back(4'd9);
        req[9] = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("latency early", int'({validF, validR}), 0);
            @(posedge clk);
        end
        #1;
        checkOutput("latency fixed", int'({validF, codeF}), 5'h19);
        checkOutput("latency rotate", int'({validR, codeR}), 5'h19);
        req[9] = 1'b0;
        @(posedge clk); #1;
        checkOutput("valid drop", int'({validF, validR}), 0);
        idle(6);
        checkOutput("no lost", lostFixed + lostRotate, 0);

        // Simultaneous req[3] and req[12].
        acceptFixed.delete();
        expFixed.push_back(4'd3);
        expFixed.push_back(4'd12);
        expRotate.push_back(4'd12);
        expRotate.push_back(4'd3);
        applyStimulus(bitOf(3) | bitOf(12), 3);
        idle(10);
        checkOutput("fixed spacing",
                    (acceptFixed.size() == 2) ? acceptFixed[1] - acceptFixed[0] : -1, 2);

        // Round robin: make 5 the last accepted index, then pend {0,5,15}.
        expFixed.push_back(4'd5);
        expRotate.push_back(4'd5);
        applyStimulus(bitOf(5), 3);
        idle(8);
        ready = 1'b0;
        expFixed.push_back(4'd0);
        expFixed.push_back(4'd5);
        expFixed.push_back(4'd15);
        expRotate.push_back(4'd15);
        expRotate.push_back(4'd0);
        expRotate.push_back(4'd5);
        applyStimulus(bitOf(0) | bitOf(5) | bitOf(15), 3);
        idle(4);
        checkOutput("rr first fixed", int'({validF, codeF}), 5'h10);
        checkOutput("rr first rotate", int'({validR, codeR}), 5'h1F);
        ready = 1'b1;
        idle(12);

        // Backpressure with a repeated edge on req[7].
        lostFixed  = 0;
        lostRotate = 0;
        ready      = 1'b0;
        expFixed.push_back(4'd7);
        expRotate.push_back(4'd7);
        applyStimulus(bitOf(7), 3);
        waitValid("bp valid");
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            checkOutput("bp hold fixed", int'({validF, codeF}), 5'h17);
            checkOutput("bp hold rotate", int'({validR, codeR}), 5'h17);
            if (i == 3) req[7] = 1'b1;
            if (i == 6) req[7] = 1'b0;
        end
        checkOutput("lost fixed", lostFixed, 1);
        checkOutput("lost rotate", lostRotate, 1);
        ready = 1'b1;
        idle(10);

        // EN dropped while 0010 is presented; edges during EN=0 vanish.
        ready = 1'b0;
        applyStimulus(bitOf(2), 3);
        waitValid("en valid");
        checkOutput("en code fixed", int'(codeF), 2);
        checkOutput("en code rotate", int'(codeR), 2);
        @(posedge clk); #1;
        EN = 1'b0;
        @(posedge clk); #1;
        checkOutput("en off fixed", int'({validF, codeF}), 0);
        checkOutput("en off rotate", int'({validR, codeR}), 0);
        applyStimulus(bitOf(4), 3);
        idle(5);
        EN    = 1'b1;
        ready = 1'b1;
        idle(12);

        // Asynchronous reset in the middle of a presented code.
        ready = 1'b0;
        applyStimulus(bitOf(1), 3);
        waitValid("rst valid");
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async rst fixed", int'({lostF, validF, codeF}), 0);
        checkOutput("async rst rotate", int'({lostR, validR, codeR}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready = 1'b1;
        idle(10);

        checkOutput("queue fixed", expFixed.size(), 0);
        checkOutput("queue rotate", expRotate.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
